// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_pkg
// Description : Shared types and helpers for sel_mux_skid and skid_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

  localparam int STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer
// Description : Two-entry valid/ready buffer (main + skid) with sync flush.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer
  import mux_pkg::*;
#(
  parameter int PAYLOAD_W = 65
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [PAYLOAD_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [PAYLOAD_W-1:0] out_data_o
);

  skid_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 w_accept;
  logic                 w_pop;

  // Both handshake flags decode only the state register, so out_ready never reaches in_ready.
  assign in_ready_o  = (state_q != TWO);
  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;

  assign w_accept = in_valid_i && in_ready_o;
  assign w_pop    = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (w_accept) begin
            main_d  = in_data_i;
            state_d = ONE;
          end
        end
        ONE: begin
          if (w_accept && w_pop) begin
            main_d = in_data_i;
          end else if (w_accept) begin
            skid_d  = in_data_i;
            state_d = TWO;
          end else if (w_pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sel_mux_skid.sv
`default_nettype none
// ============================================================================
// Module      : sel_mux_skid
// Description : N-input select mux feeding a registered 2-entry skid stage.
//               Define MUX_SKID_PERF_EN to add the saturating stall_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module sel_mux_skid
  import mux_pkg::*;
#(
  parameter  int WIDTH  = 64,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err
`ifdef MUX_SKID_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0]  stall_cnt
`endif
);

  logic [WIDTH-1:0] w_words [NUM_IN];
  logic [WIDTH-1:0] w_word;
  logic             w_sel_err;
  logic [WIDTH:0]   w_out_payload;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
    assign w_words[k] = data_in[k*WIDTH +: WIDTH];
  end

  if ((1 << SEL_W) == NUM_IN) begin : g_range_full
    assign w_sel_err = 1'b0;
  end else begin : g_range_chk
    assign w_sel_err = (int'(sel) >= NUM_IN);
  end

  // Input 0 is the fallback, so an out-of-range select still captures a defined word.
  always_comb begin
    w_word = w_words[0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) w_word = w_words[k];
    end
  end

  skid_buffer #(
    .PAYLOAD_W (WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   ({w_sel_err, w_word}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (w_out_payload)
  );

  assign out_data    = w_out_payload[WIDTH-1:0];
  assign out_sel_err = w_out_payload[WIDTH];

`ifdef MUX_SKID_PERF_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sel_mux_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_sel_mux_skid
// Description : Drives a 4-input and a 3-input sel_mux_skid in lockstep against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sel_mux_skid;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [1:0]  sel;
  logic [63:0] w [4];

  logic        in_ready4, out_valid4, err4;
  logic [63:0] out_data4;
  logic        in_ready3, out_valid3, err3;
  logic [63:0] out_data3;
`ifdef MUX_SKID_PERF_EN
  logic [31:0] stall4, stall3;
`endif

  typedef struct {
    logic [63:0] d4;
    logic [63:0] d3;
    logic        e3;
  } ent_t;

  ent_t        q[$];
  logic [63:0] last4, last3;
  logic        laste3;
  logic [31:0] mcnt;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  sel_mux_skid #(.WIDTH(64), .NUM_IN(4)) u_dut4 (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready4),
    .sel         (sel),
    .data_in     ({w[3], w[2], w[1], w[0]}),
    .out_valid   (out_valid4),
    .out_ready   (out_ready),
    .out_data    (out_data4),
    .out_sel_err (err4)
`ifdef MUX_SKID_PERF_EN
    ,
    .stall_cnt   (stall4)
`endif
  );

  sel_mux_skid #(.WIDTH(64), .NUM_IN(3)) u_dut3 (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready3),
    .sel         (sel),
    .data_in     ({w[2], w[1], w[0]}),
    .out_valid   (out_valid3),
    .out_ready   (out_ready),
    .out_data    (out_data3),
    .out_sel_err (err3)
`ifdef MUX_SKID_PERF_EN
    ,
    .stall_cnt   (stall3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid4", {63'd0, out_valid4}, {63'd0, q.size() > 0});
    chk("ready4", {63'd0, in_ready4},  {63'd0, q.size() < 2});
    chk("data4",  out_data4, last4);
    chk("err4",   {63'd0, err4}, 64'd0);
    chk("valid3", {63'd0, out_valid3}, {63'd0, q.size() > 0});
    chk("ready3", {63'd0, in_ready3},  {63'd0, q.size() < 2});
    chk("data3",  out_data3, last3);
    chk("err3",   {63'd0, err3}, {63'd0, laste3});
`ifdef MUX_SKID_PERF_EN
    chk("stall4", {32'd0, stall4}, {32'd0, mcnt});
    chk("stall3", {32'd0, stall3}, {32'd0, mcnt});
`endif
  endtask

  // One clock edge: model the FIFO-of-depth-2 contract, then compare both DUTs.
  task automatic step();
    bit   acc, pop;
    ent_t e;
    acc  = in_valid && (q.size() < 2);
    pop  = (q.size() > 0) && out_ready;
    e.d4 = w[sel];
    e.d3 = (sel < 2'd3) ? w[sel] : w[0];
    e.e3 = (sel == 2'd3);
    @(posedge clk);
    if (reset) begin
      q.delete();
      last4 = '0; last3 = '0; laste3 = 1'b0; mcnt = '0;
    end else begin
      if ((q.size() > 0) && !out_ready && (mcnt != 32'hFFFF_FFFF)) mcnt++;
      if (flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
      if (q.size() > 0) begin
        last4 = q[0].d4; last3 = q[0].d3; laste3 = q[0].e3;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1; sel = 2'd0;
    for (int k = 0; k < 4; k++) w[k] = 64'hA0 + 64'(k);
    last4 = '0; last3 = '0; laste3 = 1'b0; mcnt = '0;

    // Reset held with in_valid asserted
    repeat (2) begin
      step();
      chk("rst_valid", {63'd0, out_valid4}, 64'd0);
      chk("rst_ready", {63'd0, in_ready4}, 64'd1);
      chk("rst_data", out_data4, 64'd0);
    end

    // Streaming, one word per cycle
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sel = 2'(k);
      step();
      chk("stream_data", out_data4, 64'hA0 + 64'(k));
      chk("stream_valid", {63'd0, out_valid4}, 64'd1);
    end
    in_valid = 1'b0;
    step();

    // Back-pressure fills both entries
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; w[0] = 64'h11;
    step();
    w[0] = 64'h22;
    step();
    chk("bp_ready", {63'd0, in_ready4}, 64'd0);
    chk("bp_data", out_data4, 64'h11);
    in_valid = 1'b0;
    step();
    chk("bp_hold", out_data4, 64'h11);
    out_ready = 1'b1;
    step();
    chk("bp_second", out_data4, 64'h22);
    chk("bp_ready_again", {63'd0, in_ready4}, 64'd1);
    step();
    chk("bp_drained", {63'd0, out_valid4}, 64'd0);

    // Out-of-range select on the 3-input instance
    w[0] = 64'h55; w[2] = 64'h77; sel = 2'd3; in_valid = 1'b1;
    step();
    chk("range_data", out_data3, 64'h55);
    chk("range_err", {63'd0, err3}, 64'd1);
    sel = 2'd2;
    step();
    chk("range_ok_data", out_data3, 64'h77);
    chk("range_ok_err", {63'd0, err3}, 64'd0);
    in_valid = 1'b0;
    step();

    // Flush while holding two words, with a word offered and out_ready high
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1; w[1] = 64'h101;
    step();
    w[1] = 64'h102;
    step();
    w[1] = 64'h103; flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid", {63'd0, out_valid4}, 64'd0);
    chk("flush_ready", {63'd0, in_ready4}, 64'd1);
    in_valid = 1'b0;
    repeat (3) begin
      step();
      chk("flush_gone", {63'd0, out_valid4}, 64'd0);
    end

`ifdef MUX_SKID_PERF_EN
    reset = 1'b1;
    step();
    reset = 1'b0; out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; w[0] = 64'h5;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("perf_five", {32'd0, stall4}, 64'd5);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("perf_flush", {32'd0, stall4}, 64'd5);
    reset = 1'b1;
    step();
    chk("perf_reset", {32'd0, stall4}, 64'd0);
    reset = 1'b0;
`endif

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      sel       = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) w[k] = {$urandom, $urandom};
      flush     = ($urandom % 25) == 0;
      reset     = ($urandom % 60) == 0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
